// File: rtl/prod_to_bcd_if.sv
// Handshake and data bundle between a multiplier (master) and the
// binary-to-BCD converter (slave).
interface prod_to_bcd_if #(
  parameter int DW2    = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [DW2-1:0]        product;
  logic                  sign;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign_out;

  modport master (
    output start, product, sign,
    input  busy, done, bcd, sign_out
  );

  modport slave (
    input  start, product, sign,
    output busy, done, bcd, sign_out
  );
endinterface

// File: rtl/prod_to_bcd.sv
// Sequential double-dabble converter: one product bit per CONVERT cycle,
// result and sign published together with a one-cycle done pulse.
module prod_to_bcd #(
  parameter int DW2    = 16,
  parameter int DIGITS = 5
) (
  input  logic       clk,
  input  logic       rst,
  prod_to_bcd_if.slave bus
);
  localparam int CW = $clog2(DW2) + 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [DW2-1:0]  r_shift, w_shift_next;
  logic [BW-1:0]   r_scratch, w_scratch_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_sign, w_sign_next;
  logic [BW-1:0]   r_bcd, w_bcd_next;
  logic            r_sign_out, w_sign_out_next;

  logic [BW-1:0]     w_adj;
  logic [BW+DW2-1:0] w_dd;
  logic              w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) :
                                r_scratch[gi*4 +: 4];
    end
  endgenerate

  // Adjusted scratch and shift register move left as one word.
  assign w_dd   = {w_adj[BW-2:0], r_shift, 1'b0};
  assign w_last = (r_cnt == CW'(DW2 - 1));

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_scratch_next  = r_scratch;
    w_cnt_next      = r_cnt;
    w_sign_next     = r_sign;
    w_bcd_next      = r_bcd;
    w_sign_out_next = r_sign_out;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_shift_next   = bus.product;
          w_sign_next    = bus.sign;
          w_scratch_next = '0;
          w_cnt_next     = '0;
          w_state_next   = CONVERT;
        end
      end
      CONVERT: begin
        w_scratch_next = w_dd[BW+DW2-1:DW2];
        w_shift_next   = w_dd[DW2-1:0];
        w_cnt_next     = r_cnt + 1'b1;
        if (w_last) begin
          // Publish on entry to DONE so bcd is valid while done is high.
          w_bcd_next      = w_dd[BW+DW2-1:DW2];
          w_sign_out_next = r_sign & (|w_dd[BW+DW2-1:DW2]);
          w_state_next    = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_scratch  <= w_scratch_next;
      r_cnt      <= w_cnt_next;
      r_sign     <= w_sign_next;
      r_bcd      <= w_bcd_next;
      r_sign_out <= w_sign_out_next;
    end
  end

  assign bus.busy     = (r_state == CONVERT) || (r_state == DONE);
  assign bus.done     = (r_state == DONE);
  assign bus.bcd      = r_bcd;
  assign bus.sign_out = r_sign_out;
endmodule

// File: tb/tb_prod_to_bcd.sv
// Directed checks of prod_to_bcd: latency, boundary values, ignored starts,
// reset abort and a few model-checked random products.
module tb_prod_to_bcd;
  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  prod_to_bcd_if #(.DW2(16), .DIGITS(5)) bus ();

  prod_to_bcd #(.DW2(16), .DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Start a conversion and follow it to done; checks latency, busy and outputs.
  task automatic run(input logic [15:0] p, input logic s, input logic [19:0] exp_bcd,
                     input logic exp_sign, input string tag);
    int lat;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.product = p; bus.sign = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    check({tag, "_latency"}, lat, 16);
    check({tag, "_busy"}, {31'd0, busy_ok}, 1);
    check({tag, "_bcd"}, {12'd0, bus.bcd}, {12'd0, exp_bcd});
    check({tag, "_sign"}, {31'd0, bus.sign_out}, {31'd0, exp_sign});
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 0);
    $display("conv %s product=%0d sign=%0d -> bcd=%05h sign_out=%0d latency=%0d",
             tag, p, s, bus.bcd, bus.sign_out, lat);
  endtask

  initial begin
    int dones;
    logic [15:0] rp;
    logic rs;
    n_err = 0;
    n_chk = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.product = '0; bus.sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {9'd0, bus.busy, bus.done, bus.sign_out, bus.bcd}, 0);
    @(negedge clk);
    rst = 1'b0;

    run(16'd0,     1'b1, 20'h00000, 1'b0, "zero_neg");
    run(16'd65025, 1'b1, 20'h65025, 1'b1, "p65025");
    run(16'hFFFF,  1'b0, 20'h65535, 1'b0, "pFFFF");

    repeat (5) @(posedge clk);
    #1;
    check("hold_bcd", {12'd0, bus.bcd}, 32'h65535);

    // Starts during CONVERT and DONE must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.product = 16'd123; bus.sign = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        @(negedge clk);
        bus.start = 1'b1; bus.product = 16'd999;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (bus.done) begin
        dones++;
        check("ign_bcd", {12'd0, bus.bcd}, 32'h00123);
        bus.start = 1'b1; bus.product = 16'd999;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ign_after_done", {31'd0, bus.busy}, 0);
      end
    end
    check("ign_done_count", dones, 1);
    $display("ignore-test dones=%0d bcd=%05h", dones, bus.bcd);
    run(16'd999, 1'b0, 20'h00999, 1'b0, "p999");

    // Reset mid-conversion aborts with no done pulse and clears outputs.
    run(16'd42, 1'b1, 20'h00042, 1'b1, "p42");
    @(negedge clk);
    bus.start = 1'b1; bus.product = 16'd7; bus.sign = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outs", {9'd0, bus.busy, bus.done, bus.sign_out, bus.bcd}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("abort-test dones=%0d bcd=%05h", dones, bus.bcd);

    for (int k = 0; k < 6; k++) begin
      rp = 16'($urandom_range(0, 65025));
      rs = 1'($urandom_range(0, 1));
      run(rp, rs, to_bcd(int'(rp)), rs & (rp != 0), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/prod_to_bcd.md
PROD_TO_BCD -- requirements
Module: prod_to_bcd

Interface
REQ-001 Parameter DW2, default 16, width of the unsigned product magnitude.
REQ-002 Parameter DIGITS, default 5, number of BCD output digits; SHALL satisfy 10^DIGITS > 2^DW2 - 1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle strobe from the multiplier's ready; product and sign are valid in the same cycle.
REQ-006 product  input  DW2  unsigned product magnitude from the shift-add multiplier.
REQ-007 sign  input  1  product sign, 1 = negative.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when bcd and sign_out are updated.
REQ-010 bcd  output  4*DIGITS  packed BCD digits; bits [3:0] = units, [7:4] = tens, and so on.
REQ-011 sign_out  output  1  registered sign for the display minus segment.

Function
REQ-012 FSM states SHALL be IDLE, CONVERT and DONE.
REQ-013 In IDLE with start=1: capture product into a DW2-bit shift register, capture sign, clear the DIGITS*4-bit scratch BCD register, clear the iteration counter, go to CONVERT.
REQ-014 In IDLE with start=0: remain in IDLE; no register changes.
REQ-015 Each CONVERT cycle (double dabble):
- first, add 3 to every scratch digit >= 5;
- then shift {scratch, shift register} left by 1, so the shift register MSB enters scratch bit 0;
- increment the counter.
REQ-016 After the DW2-th CONVERT cycle (counter reaches DW2-1 and is processed), go to DONE.
REQ-017 In DONE, for exactly one cycle: load bcd from scratch, load sign_out, assert done=1, then go to IDLE.
REQ-018 Latency: start sampled at edge T; CONVERT occupies cycles T+1..T+DW2; done=1 in cycle T+DW2+1 (T+17 at default).
REQ-019 busy SHALL be 1 exactly when the state is CONVERT or DONE.
REQ-020 start while busy=1 (including the DONE cycle) SHALL be ignored; it is not queued.
REQ-021 bcd and sign_out SHALL hold their values between done pulses.
REQ-022 When the converted product is 0, sign_out SHALL be 0 regardless of sign (no negative zero).
REQ-023 Every scratch digit SHALL remain within 0..9 at the end of each CONVERT cycle.
REQ-024 The counter SHALL be $clog2(DW2)+1 bits wide and SHALL never wrap during a conversion.

Reset
REQ-025 rst=1 at any edge: state=IDLE, busy=0, done=0, bcd=0, sign_out=0; shift register, scratch and counter cleared.
REQ-026 rst asserted mid-conversion SHALL abort the conversion with no done pulse; prior bcd is lost (cleared).
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 product=16'd0, sign=1, start at T -> done at T+17, bcd=20'h00000, sign_out=0.
REQ-029 product=16'd65025, sign=1 -> bcd=20'h65025, sign_out=1, busy high T+1..T+17.
REQ-030 product=16'hFFFF, sign=0 -> bcd=20'h65535, sign_out=0.
REQ-031 start with product=16'd123, then start with 16'd999 at T+5 and again in the DONE cycle -> single done, bcd=20'h00123; a fresh start in IDLE afterwards converts 999 to 20'h00999.
REQ-032 Convert 16'd42 to done (bcd=20'h00042), start 16'd7, assert rst at T+8 -> no done, bcd=0, sign_out=0, busy=0 from the next edge.
REQ-033 Randomised products 0..65025 with random sign -> bcd equals the decimal magnitude and sign_out = sign AND (product != 0), checked against a reference model.
